// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice: FSM states,
// BCD digit moduli and the field layout of the 24-bit display word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_LAP     = 2'd2,
    ST_PAUSED  = 2'd3
  } sw_state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DISPLAY_W  = DIGIT_W * NUM_DIGITS;

  localparam int unsigned MOD_DEC = 10;
  localparam int unsigned MOD_SEX = 6;

  // Bit offsets of each digit inside {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones}
  localparam int unsigned OFS_CS_ONES = 0;
  localparam int unsigned OFS_CS_TENS = 4;
  localparam int unsigned OFS_S_ONES  = 8;
  localparam int unsigned OFS_S_TENS  = 12;
  localparam int unsigned OFS_M_ONES  = 16;
  localparam int unsigned OFS_M_TENS  = 20;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with synchronous clear; carry is combinational so
// a chain of digits ripples within a single cycle.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MODULUS = MOD_DEC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic at_max;

  assign at_max = (q == DIGIT_W'(MODULUS - 1));
  assign carry  = inc && at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch FSM, centisecond prescaler, mm:ss.cc BCD count and lap freeze
// feeding the display driver.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_stop_down,
  input  logic                 reset_lap_down,
  output logic                 running,
  output logic                 lap_active,
  output logic [DISPLAY_W-1:0] display_bcd,
  output logic                 wrap
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  sw_state_t            state;
  sw_state_t            next_state;
  logic                 lap_load;
  logic                 counting;
  logic                 tick;
  logic                 clr;
  logic [PRE_W-1:0]     presc;
  logic [NUM_DIGITS-1:0] inc;
  logic [NUM_DIGITS-1:0] carry;
  logic [DIGIT_W-1:0]   digit_q [NUM_DIGITS];
  logic [DISPLAY_W-1:0] live_bcd;
  logic [DISPLAY_W-1:0] lap_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; start/stop takes priority over reset/lap
  always_comb begin
    next_state = state;
    lap_load   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_stop_down) next_state = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (start_stop_down) begin
          next_state = ST_PAUSED;
        end else if (reset_lap_down) begin
          next_state = ST_LAP;
          lap_load   = 1'b1;
        end
      end
      ST_LAP: begin
        if (start_stop_down)     next_state = ST_PAUSED;
        else if (reset_lap_down) next_state = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (start_stop_down)     next_state = ST_RUNNING;
        else if (reset_lap_down) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign counting = (state == ST_RUNNING) || (state == ST_LAP);
  assign tick     = counting && (presc == PRE_W'(DIV - 1));
  assign clr      = (next_state == ST_IDLE);

  // Prescaler freezes while paused so a partial tick survives a pause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr || tick) begin
      presc <= '0;
    end else if (counting) begin
      presc <= presc + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int unsigned MOD = ((i == 3) || (i == 5)) ? MOD_SEX : MOD_DEC;

    if (i == 0) begin : g_first
      assign inc[i] = tick;
    end else begin : g_chain
      assign inc[i] = carry[i-1];
    end

    bcd_digit #(
      .MODULUS (MOD)
    ) u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[i]),
      .q     (digit_q[i]),
      .carry (carry[i])
    );
  end

  always_comb begin
    live_bcd = '0;
    live_bcd[OFS_CS_ONES +: DIGIT_W] = digit_q[0];
    live_bcd[OFS_CS_TENS +: DIGIT_W] = digit_q[1];
    live_bcd[OFS_S_ONES  +: DIGIT_W] = digit_q[2];
    live_bcd[OFS_S_TENS  +: DIGIT_W] = digit_q[3];
    live_bcd[OFS_M_ONES  +: DIGIT_W] = digit_q[4];
    live_bcd[OFS_M_TENS  +: DIGIT_W] = digit_q[5];
  end

  // Lap capture takes the pre-edge count, so a coincident tick is excluded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q <= '0;
    end else if (clr) begin
      lap_q <= '0;
    end else if (lap_load) begin
      lap_q <= live_bcd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running    <= 1'b0;
      lap_active <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      running    <= (next_state == ST_RUNNING) || (next_state == ST_LAP);
      lap_active <= (next_state == ST_LAP);
      wrap       <= carry[NUM_DIGITS-1];
    end
  end

  assign display_bcd = lap_active ? lap_q : live_bcd;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench: a DIV=10 instance for FSM/lap/pause behaviour and a
// DIV=2 instance for the full 59:59.99 rollover and async reset.
module tb_stopwatch_control;

  logic        clk;
  logic        rst_n;
  logic        ss;
  logic        rl;
  logic        ss_w;
  logic        rl_w;
  logic        running;
  logic        lap_active;
  logic [23:0] display_bcd;
  logic        wrap;
  logic        running_w;
  logic        lap_active_w;
  logic [23:0] display_bcd_w;
  logic        wrap_w;

  int n_checks = 0;
  int n_pass   = 0;

  stopwatch_control #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_stop_down (ss),
    .reset_lap_down  (rl),
    .running         (running),
    .lap_active      (lap_active),
    .display_bcd     (display_bcd),
    .wrap            (wrap)
  );

  stopwatch_control #(
    .CLK_HZ  (200),
    .TICK_HZ (100)
  ) u_dut_w (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_stop_down (ss_w),
    .reset_lap_down  (rl_w),
    .running         (running_w),
    .lap_active      (lap_active_w),
    .display_bcd     (display_bcd_w),
    .wrap            (wrap_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic r);
    ss = s;
    rl = r;
    step(1);
    ss = 1'b0;
    rl = 1'b0;
  endtask

  task automatic pulse_w(input logic s, input logic r);
    ss_w = s;
    rl_w = r;
    step(1);
    ss_w = 1'b0;
    rl_w = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    ss    = 1'b0;
    rl    = 1'b0;
    ss_w  = 1'b0;
    rl_w  = 1'b0;
    #3 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    check("rst_running",    32'(running),     32'h0);
    check("rst_lap_active", 32'(lap_active),  32'h0);
    check("rst_display",    32'(display_bcd), 32'h0);
    check("rst_wrap",       32'(wrap),        32'h0);

    // Start, first tick after DIV edges, tenth tick after 100
    step(4);
    pulse(1'b1, 1'b0);
    check("start_running",   32'(running),     32'h1);
    check("start_display",   32'(display_bcd), 32'h0);
    step(9);
    check("pre_first_tick",  32'(display_bcd), 32'h0);
    step(1);
    check("first_tick",      32'(display_bcd), 32'h000001);
    step(90);
    check("tenth_tick",      32'(display_bcd), 32'h000010);
    step(9850);
    check("tick_995",        32'(display_bcd), 32'h000995);

    // Pause holds the count and the sub-tick fraction
    pulse(1'b1, 1'b0);
    check("pause_running",   32'(running),     32'h0);
    check("pause_display",   32'(display_bcd), 32'h000995);
    step(200);
    check("pause_hold",      32'(display_bcd), 32'h000995);
    pulse(1'b1, 1'b0);
    check("resume_running",  32'(running),     32'h1);
    step(8);
    check("resume_pre_tick", 32'(display_bcd), 32'h000995);
    step(1);
    check("resume_tick",     32'(display_bcd), 32'h000996);
    step(39);
    check("count_999",       32'(display_bcd), 32'h000999);
    step(1);
    check("count_1000",      32'(display_bcd), 32'h001000);

    // Pause after 3 prescaler counts: next increment 7 running cycles later
    step(2);
    pulse(1'b1, 1'b0);
    step(20);
    pulse(1'b1, 1'b0);
    step(6);
    check("frac_pre_tick",   32'(display_bcd), 32'h001000);
    step(1);
    check("frac_tick",       32'(display_bcd), 32'h001001);

    // Pause then reset to idle; reset/lap in idle is ignored
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check("idle_display",    32'(display_bcd), 32'h0);
    check("idle_running",    32'(running),     32'h0);
    pulse(1'b0, 1'b1);
    check("idle_rl_ignored", 32'(running),     32'h0);

    // Lap at 00:01.23, frozen for 50 ticks, released at 00:01.73
    pulse(1'b1, 1'b0);
    step(1230);
    check("pre_lap_count",   32'(display_bcd), 32'h000123);
    pulse(1'b0, 1'b1);
    check("lap_active",      32'(lap_active),  32'h1);
    check("lap_running",     32'(running),     32'h1);
    check("lap_display",     32'(display_bcd), 32'h000123);
    step(499);
    check("lap_frozen",      32'(display_bcd), 32'h000123);
    pulse(1'b0, 1'b1);
    check("unlap_display",   32'(display_bcd), 32'h000173);
    check("unlap_active",    32'(lap_active),  32'h0);
    check("unlap_running",   32'(running),     32'h1);

    // Lap then start/stop: pause with the live count shown
    pulse(1'b0, 1'b1);
    check("lap2_active",     32'(lap_active),  32'h1);
    check("lap2_display",    32'(display_bcd), 32'h000173);
    pulse(1'b1, 1'b0);
    check("lap_pause_active",  32'(lap_active),  32'h0);
    check("lap_pause_running", 32'(running),     32'h0);
    check("lap_pause_display", 32'(display_bcd), 32'h000173);

    // Both buttons in the same cycle while running: start/stop wins
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check("both_running",    32'(running),     32'h0);
    check("both_lap_active", 32'(lap_active),  32'h0);
    check("both_display",    32'(display_bcd), 32'h000173);
    pulse(1'b0, 1'b1);
    check("both_idle",       32'(display_bcd), 32'h0);
    check("both_idle_run",   32'(running),     32'h0);

    // DIV=2 instance: run through the full hour rollover
    check("w_rst_display",   32'(display_bcd_w), 32'h0);
    pulse_w(1'b1, 1'b0);
    check("w_running",       32'(running_w),     32'h1);
    step(12000);
    check("w_one_minute",    32'(display_bcd_w), 32'h010000);
    step(108000);
    check("w_ten_minutes",   32'(display_bcd_w), 32'h100000);
    step(599998);
    check("w_max_display",   32'(display_bcd_w), 32'h595999);
    check("w_max_wrap",      32'(wrap_w),        32'h0);
    step(1);
    check("w_pre_wrap",      32'(wrap_w),        32'h0);
    step(1);
    check("w_wrap_display",  32'(display_bcd_w), 32'h0);
    check("w_wrap_pulse",    32'(wrap_w),        32'h1);
    check("w_wrap_running",  32'(running_w),     32'h1);
    step(1);
    check("w_wrap_single",   32'(wrap_w),        32'h0);
    step(10);
    check("w_post_wrap",     32'(display_bcd_w), 32'h000005);

    // Asynchronous reset mid-count clears outputs without a clock edge
    rst_n = 1'b0;
    #1;
    check("w_arst_display",  32'(display_bcd_w), 32'h0);
    check("w_arst_running",  32'(running_w),     32'h0);
    check("w_arst_lap",      32'(lap_active_w),  32'h0);
    check("w_arst_wrap",     32'(wrap_w),        32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_control.md
# stopwatch_control

Control and timekeeping stage that consumes the single-cycle `down` pulses from two debounced buttons (start/stop and reset/lap). It runs a four-state stopwatch FSM, divides the system clock to a centisecond tick, and keeps an mm:ss.cc BCD count. It presents a live or lap-frozen value to the display driver downstream.

## Interface

Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 100, count rate.
- Constraints: `CLK_HZ % TICK_HZ == 0`; `DIV = CLK_HZ/TICK_HZ >= 2`.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_stop_down`  in  1  one-cycle pulse per press, already synchronous to `clk`.
- `reset_lap_down`  in  1  one-cycle pulse per press, already synchronous to `clk`.
- `running`  out  1  high in RUNNING or LAP.
- `lap_active`  out  1  high in LAP.
- `display_bcd`  out  24  {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones}, 4 bits each.
- `wrap`  out  1  one-cycle pulse when the count rolls from 59:59.99 to 00:00.00.

## Operation

- States: IDLE, RUNNING, LAP, PAUSED. "ss" denotes `start_stop_down`; "rl" denotes `reset_lap_down`.
- IDLE:
  - ss → RUNNING.
  - rl ignored.
  - Count and prescaler are held at 0.
- RUNNING:
  - ss → PAUSED.
  - rl → LAP; the live count is latched into the lap register on the same edge.
- LAP:
  - Counting continues and the display shows the lap register.
  - rl → RUNNING (display unfreezes).
  - ss → PAUSED (display unfreezes and shows the live count).
- PAUSED:
  - ss → RUNNING.
  - rl → IDLE, clearing count, prescaler and lap register.
- If ss and rl arrive on the same cycle, ss wins and rl is dropped.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING/LAP.
  - Holds its value in PAUSED, so a sub-tick fraction is preserved across a pause.
  - Cleared only in IDLE or by reset.
- Tick = prescaler == DIV-1 while RUNNING or LAP. On a tick the prescaler returns to 0 and the BCD count increments.
- BCD chain moduli:
  - cs_ones 10, cs_tens 10, s_ones 10, s_tens 6, m_ones 10, m_tens 6.
  - A carry ripples within the same cycle.
- Wrap: 59:59.99 + tick → 00:00.00, `wrap`=1 for that cycle, and the state is unchanged.
- `display_bcd` = lap register when `lap_active`, otherwise the live count. It is a mux of registers with no extra pipeline stage.
- Reset (async assert, any state): state IDLE; count, prescaler and lap register 0; all outputs 0. The reset takes effect immediately, mid-run included.

## Timing

- A pulse sampled at edge N changes the state at edge N; `running`/`lap_active` reflect it after edge N.
- First tick after IDLE→RUNNING at edge N: the count reads 00:00.01 after edge N+DIV.
- Pause/resume: total RUNNING cycles per increment is exactly DIV, regardless of pauses.
- The lap latch captures the count value present before edge N. A tick coinciding with the rl edge is not included in the latched value.
- `wrap` is high exactly one cycle, coincident with the count becoming 00:00.00.
- Inputs are assumed to be one cycle wide. A multi-cycle high is treated as one event per cycle and is not filtered.

## Structure

- `stopwatch_pkg`:
  - state enum type (IDLE, RUNNING, LAP, PAUSED);
  - digit modulus constants (10, 6);
  - display field offsets.
- Sub-module `bcd_digit`:
  - Parameters: `MODULUS`.
  - Ports: `clk`, `rst_n`, `clr`, `inc`, `q[3:0]`, `carry` (= `inc` && `q` == MODULUS-1).
  - Instantiated six times, chained carry→inc.
- Top: FSM, prescaler ($clog2(DIV) bits), lap register, output mux.

## Test plan

Use CLK_HZ=1000, TICK_HZ=100 (DIV=10) unless noted.

- Reset then an ss pulse at cycle 5:
  - `running`=1 from cycle 6;
  - display 00:00.01 after 10 further edges;
  - 00:00.10 after 100.
- Run for 995 ticks then pause (ss):
  - display holds 00:09.95 indefinitely;
  - resume, 5 ticks → 00:10.00.
- Pause after 3 prescaler counts, resume:
  - the next increment arrives 7 RUNNING cycles later.
- At 00:01.23, rl → LAP:
  - display frozen at 00:01.23 for 50 ticks while the internal count reaches 00:01.73;
  - rl again → display 00:01.73, `lap_active`=0.
- ss and rl asserted on the same cycle in RUNNING:
  - → PAUSED, lap register untouched;
  - rl in PAUSED → IDLE, display 00:00.00.
- DIV=2, run 360000 ticks:
  - 59:59.99 → 00:00.00 with a single-cycle `wrap`;
  - assert `rst_n` low mid-count → all outputs 0 immediately.
